// File: rtl/comm_pkg.sv
// Shared opcodes, response codes and FSM encoding for the
// parametrised console command block.
package comm_pkg;

  localparam logic [7:0] COMM_READ_PIN_MAP      = 8'h01;
  localparam logic [7:0] COMM_READ_ENABLE_MASK  = 8'h02;
  localparam logic [7:0] COMM_WRITE_ENABLE_MASK = 8'h03;
  localparam logic [7:0] COMM_WRITE_PIN_MAP     = 8'h04;

  localparam logic [7:0] COMM_ACK = 8'hA5;
  localparam logic [7:0] COMM_NAK = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_ARG,
    ST_TX_LOAD,
    ST_TX_WAIT
  } comm_state_e;

  function automatic int cnt_width(int a, int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/comm_ctrl_param_if.sv
// Byte-stream handshake between uart_rx/uart_tx and the
// command block.
interface comm_ctrl_param_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;

  modport slave (
    input  rx_valid, rx_data, tx_done,
    output tx_data, tx_start
  );

  modport master (
    output rx_valid, rx_data, tx_done,
    input  tx_data, tx_start
  );
endinterface

// File: rtl/comm_resp_ser.sv
// Load/shift-right response serialiser; owns the
// tx_start/tx_done handshake with uart_tx.
module comm_resp_ser
  import comm_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [63:0]   data,
  input  logic [CW-1:0] nbytes,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_done,
  output logic          busy
);

  comm_state_e   state_q, state_d;
  logic [63:0]   sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_TX_LOAD: state_d = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (tx_done) begin
          sh_d    = sh_q >> 8;
          cnt_d   = cnt_q - CW'(1);
          state_d = (cnt_q == CW'(1)) ? ST_IDLE : ST_TX_LOAD;
        end
      end
      default: begin
        if (load && nbytes != '0) begin
          sh_d    = data;
          cnt_d   = nbytes;
          state_d = ST_TX_LOAD;
        end
      end
    endcase
  end

  assign tx_start = (state_q == ST_TX_LOAD);
  assign tx_data  = sh_q[7:0];
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: rtl/comm_ctrl_param.sv
// Opcode decoder, argument collector with timeout, and the
// enable-mask / pin-map registers.
module comm_ctrl_param
  import comm_pkg::*;
#(
  parameter int NUM_CHANNELS  = 16,
  parameter int PIN_MAP_BYTES = 4,
  parameter logic [NUM_CHANNELS-1:0] MASK_RESET = 16'haa55,
  parameter logic [8*PIN_MAP_BYTES-1:0] PIN_MAP_RESET = 32'haabbccdd,
  parameter int RX_TIMEOUT    = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  comm_ctrl_param_if.slave           bus,
  output logic [NUM_CHANNELS-1:0]    enabled_out,
  output logic [8*PIN_MAP_BYTES-1:0] pin_map_out,
  output logic                       busy
);

  localparam int MASK_BYTES = NUM_CHANNELS / 8;
  localparam int PW = 8 * PIN_MAP_BYTES;
  localparam int CW = cnt_width(PIN_MAP_BYTES, MASK_BYTES);
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(RX_TIMEOUT);

  comm_state_e       state_q, state_d;
  logic              wr_mask_q, wr_mask_d;
  logic [CW-1:0]     arg_cnt_q, arg_cnt_d;
  logic [63:0]       stage_q, stage_d, stage_nxt;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [PW-1:0]     pin_q, pin_d;

  logic              ser_load, ser_busy;
  logic [63:0]       ser_data, mask_ext, pin_ext;
  logic [CW-1:0]     ser_nbytes, arg_last;
  logic [7:0]        op;

  assign op = bus.rx_data;
  assign arg_last = wr_mask_q ? CW'(MASK_BYTES - 1)
                              : CW'(PIN_MAP_BYTES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_mask_q <= 1'b0;
      arg_cnt_q <= '0;
      stage_q   <= '0;
      tmo_q     <= '0;
      mask_q    <= MASK_RESET;
      pin_q     <= PIN_MAP_RESET;
    end else begin
      state_q   <= state_d;
      wr_mask_q <= wr_mask_d;
      arg_cnt_q <= arg_cnt_d;
      stage_q   <= stage_d;
      tmo_q     <= tmo_d;
      mask_q    <= mask_d;
      pin_q     <= pin_d;
    end
  end

  always_comb begin
    mask_ext = '0;
    mask_ext[NUM_CHANNELS-1:0] = mask_q;
    pin_ext = '0;
    pin_ext[PW-1:0] = pin_q;
    stage_nxt = stage_q;
    stage_nxt[{arg_cnt_q, 3'b000} +: 8] = bus.rx_data;
  end

  always_comb begin
    state_d    = state_q;
    wr_mask_d  = wr_mask_q;
    arg_cnt_d  = arg_cnt_q;
    stage_d    = stage_q;
    tmo_d      = tmo_q;
    mask_d     = mask_q;
    pin_d      = pin_q;
    ser_load   = 1'b0;
    ser_data   = '0;
    ser_nbytes = '0;
    unique case (state_q)
      ST_RX_ARG: begin
        // An arriving byte takes priority over a same-cycle expiry.
        if (bus.rx_valid) begin
          stage_d   = stage_nxt;
          arg_cnt_d = arg_cnt_q + CW'(1);
          tmo_d     = TMO_LOAD;
          if (arg_cnt_q == arg_last) begin
            if (wr_mask_q) mask_d = stage_nxt[NUM_CHANNELS-1:0];
            else           pin_d  = stage_nxt[PW-1:0];
            ser_load   = 1'b1;
            ser_data   = 64'(COMM_ACK);
            ser_nbytes = CW'(1);
            state_d    = ST_IDLE;
          end
        end else if (tmo_q <= TW'(1)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      default: begin
        if (bus.rx_valid && !ser_busy) begin
          unique case (1'b1)
            op == COMM_READ_PIN_MAP: begin
              ser_load   = 1'b1;
              ser_data   = pin_ext;
              ser_nbytes = CW'(PIN_MAP_BYTES);
            end
            op == COMM_READ_ENABLE_MASK: begin
              ser_load   = 1'b1;
              ser_data   = mask_ext;
              ser_nbytes = CW'(MASK_BYTES);
            end
            op == COMM_WRITE_ENABLE_MASK,
            op == COMM_WRITE_PIN_MAP: begin
              state_d   = ST_RX_ARG;
              wr_mask_d = (op == COMM_WRITE_ENABLE_MASK);
              arg_cnt_d = '0;
              stage_d   = '0;
              tmo_d     = TMO_LOAD;
            end
            default: begin
              ser_load   = 1'b1;
              ser_data   = 64'(COMM_NAK);
              ser_nbytes = CW'(1);
            end
          endcase
        end
      end
    endcase
  end

  comm_resp_ser #(
    .CW(CW)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .data     (ser_data),
    .nbytes   (ser_nbytes),
    .tx_data  (bus.tx_data),
    .tx_start (bus.tx_start),
    .tx_done  (bus.tx_done),
    .busy     (ser_busy)
  );

  assign enabled_out = mask_q;
  assign pin_map_out = pin_q;
  assign busy = (state_q != ST_IDLE) || ser_busy;

endmodule

// File: tb/tb_comm_ctrl_param.sv
// Randomised bench for comm_ctrl_param: byte-level host and
// uart_tx responder against a register/reply model.
module tb_comm_ctrl_param;
  import comm_pkg::*;

  localparam int NC  = 16;
  localparam int PB  = 4;
  localparam int MB  = NC / 8;
  localparam int PW  = 8 * PB;
  localparam int TMO = 4096;
  localparam logic [NC-1:0] MR = 16'haa55;
  localparam logic [PW-1:0] PR = 32'haabbccdd;

  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0] enabled_out;
  logic [PW-1:0] pin_map_out;
  logic busy;

  comm_ctrl_param_if bus();

  comm_ctrl_param #(
    .NUM_CHANNELS  (NC),
    .PIN_MAP_BYTES (PB),
    .MASK_RESET    (MR),
    .PIN_MAP_RESET (PR),
    .RX_TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .enabled_out (enabled_out),
    .pin_map_out (pin_map_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [NC-1:0] mask_m;
  logic [PW-1:0] pin_m;

  // uart_tx stand-in: random byte times, stray tx_done pulses when idle
  logic [7:0] rx_q[$];
  int st_q[$];
  int dn_q[$];
  int cd = 0;
  int tx_viol = 0;
  logic [7:0] held = 8'h00;
  bit hold_chk = 1'b0;

  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (rst) hold_chk = 1'b0;
      if (hold_chk && (bus.tx_data !== held || bus.tx_start !== 1'b0))
        tx_viol++;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.tx_done = 1'b1;
          dn_q.push_back(cyc);
          hold_chk = 1'b0;
        end
      end else if (bus.tx_start === 1'b1) begin
        if ($isunknown(bus.tx_data)) tx_viol++;
        rx_q.push_back(bus.tx_data);
        st_q.push_back(cyc);
        held = bus.tx_data;
        hold_chk = 1'b1;
        cd = int'($urandom_range(1, 10));
      end else if ($urandom_range(0, 3) == 0) begin
        bus.tx_done = 1'b1;
      end
    end
  end

  task automatic run_cmd(
    input  logic [7:0] b[$],
    input  int exp_n,
    input  int last_gap,
    input  bit inject,
    output logic [63:0] v,
    output int n,
    output int lb,
    output logic [NC-1:0] pm,
    output logic [NC-1:0] qm,
    output logic [PW-1:0] pp,
    output logic [PW-1:0] qp
  );
    int sent, g, t;
    rx_q.delete();
    st_q.delete();
    dn_q.delete();
    lb = 0;
    sent = 0;
    pm = enabled_out; qm = enabled_out;
    pp = pin_map_out; qp = pin_map_out;
    @(negedge clk);
    foreach (b[i]) begin
      if (i > 0) begin
        g = (i == b.size() - 1 && last_gap >= 0) ? last_gap
                                                 : int'($urandom_range(0, 3));
        repeat (g) @(negedge clk);
      end
      if (i == b.size() - 1) begin
        pm = enabled_out;
        pp = pin_map_out;
        sent = cyc;
      end
      bus.rx_valid = 1'b1;
      bus.rx_data = b[i];
      @(negedge clk);
      bus.rx_valid = 1'b0;
      qm = enabled_out;
      qp = pin_map_out;
    end
    if (inject) begin
      t = 0;
      while (st_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
      bus.rx_valid = 1'b1;
      bus.rx_data = COMM_READ_ENABLE_MASK;
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    t = 0;
    while ((rx_q.size() < exp_n || cd != 0 || busy) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6000) lb += 1000;
    repeat (20) @(negedge clk);
    n = rx_q.size();
    v = '0;
    for (int i = 0; i < n && i < 8; i++) v[8*i +: 8] = rx_q[i];
    if (st_q.size() > 0 && st_q[0] != sent + 1) lb++;
    for (int i = 1; i < st_q.size() && i <= dn_q.size(); i++)
      if (st_q[i] != dn_q[i-1] + 1) lb++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (enabled_out !== MR || pin_map_out !== PR) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h expected %h/%h",
               enabled_out, pin_map_out, MR, PR);
    end
    checks++;
    if (busy !== 1'b0 || bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs: got busy=%b start=%b data=%h expected 0/0/00",
               busy, bus.tx_start, bus.tx_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || enabled_out !== MR) begin
      errors++;
      $display("FAIL post_reset: got busy=%b mask=%h expected 0/%h",
               busy, enabled_out, MR);
    end
  endtask

  task automatic test_read_all(input string tag);
    logic [7:0] q[$];
    logic [63:0] v;
    int n, lb;
    logic [NC-1:0] a, b;
    logic [PW-1:0] c, d;
    q.push_back(COMM_READ_PIN_MAP);
    run_cmd(q, PB, -1, 1'b0, v, n, lb, a, b, c, d);
    checks++;
    if (n !== PB || v !== 64'(pin_m) || lb !== 0) begin
      errors++;
      $display("FAIL %s_rd_pin: got n=%0d %h lat=%0d expected n=%0d %h lat=0",
               tag, n, v, lb, PB, 64'(pin_m));
    end
    q.delete();
    q.push_back(COMM_READ_ENABLE_MASK);
    run_cmd(q, MB, -1, 1'b0, v, n, lb, a, b, c, d);
    checks++;
    if (n !== MB || v !== 64'(mask_m) || lb !== 0) begin
      errors++;
      $display("FAIL %s_rd_mask: got n=%0d %h lat=%0d expected n=%0d %h lat=0",
               tag, n, v, lb, MB, 64'(mask_m));
    end
  endtask

  task automatic test_write(input bit is_mask, input logic [63:0] val,
                            input int last_gap, input string tag);
    logic [7:0] q[$];
    logic [63:0] v;
    int n, lb, nb;
    logic [NC-1:0] pm, qm, em;
    logic [PW-1:0] pp, qp, ep;
    nb = is_mask ? MB : PB;
    q.push_back(is_mask ? COMM_WRITE_ENABLE_MASK : COMM_WRITE_PIN_MAP);
    for (int i = 0; i < nb; i++) q.push_back(val[8*i +: 8]);
    run_cmd(q, 1, last_gap, 1'b0, v, n, lb, pm, qm, pp, qp);
    em = is_mask ? val[NC-1:0] : mask_m;
    ep = is_mask ? pin_m : val[PW-1:0];
    checks++;
    if (n !== 1 || v !== 64'(COMM_ACK) || lb !== 0) begin
      errors++;
      $display("FAIL %s_ack: got n=%0d %h lat=%0d expected n=1 a5 lat=0",
               tag, n, v, lb);
    end
    checks++;
    if (pm !== mask_m || pp !== pin_m || qm !== em || qp !== ep) begin
      errors++;
      $display("FAIL %s_commit: got pre %h/%h post %h/%h expected pre %h/%h post %h/%h",
               tag, pm, pp, qm, qp, mask_m, pin_m, em, ep);
    end
    mask_m = em;
    pin_m = ep;
  endtask

  task automatic test_read();
    test_read_all("t1a");
    test_read_all("t1b");
  endtask

  task automatic test_write_mask();
    test_write(1'b1, 64'h1234, -1, "t2");
    test_read_all("t2");
  endtask

  task automatic test_write_pin();
    test_write(1'b0, 64'h12345678, -1, "t3");
    test_read_all("t3");
  endtask

  task automatic test_random_writes();
    for (int k = 0; k < 4; k++) begin
      test_write(1'b1, 64'($urandom()), -1, "rnd_m");
      test_write(1'b0, {32'($urandom()), 32'($urandom())}, -1, "rnd_p");
      test_read_all("rnd");
    end
  endtask

  task automatic test_nak();
    logic [7:0] ops[$];
    logic [7:0] q[$];
    logic [63:0] v;
    int n, lb;
    logic [NC-1:0] a, b;
    logic [PW-1:0] c, d;
    ops.push_back(8'h7F);
    ops.push_back(8'h00);
    ops.push_back(8'hFF);
    repeat (3) ops.push_back(8'($urandom_range(5, 255)));
    foreach (ops[i]) begin
      q.delete();
      q.push_back(ops[i]);
      run_cmd(q, 1, -1, 1'b0, v, n, lb, a, b, c, d);
      checks++;
      if (n !== 1 || v !== 64'(COMM_NAK) || lb !== 0) begin
        errors++;
        $display("FAIL nak_%h: got n=%0d %h lat=%0d expected n=1 ee lat=0",
                 ops[i], n, v, lb);
      end
      checks++;
      if (enabled_out !== mask_m || pin_map_out !== pin_m || busy !== 1'b0) begin
        errors++;
        $display("FAIL nak_regs_%h: got %h/%h busy=%b expected %h/%h busy=0",
                 ops[i], enabled_out, pin_map_out, busy, mask_m, pin_m);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] q[$];
    logic [63:0] v;
    int n, lb;
    logic [NC-1:0] a, b;
    logic [PW-1:0] c, d;
    q.push_back(COMM_WRITE_ENABLE_MASK);
    q.push_back(8'hFF);
    run_cmd(q, 0, -1, 1'b0, v, n, lb, a, b, c, d);
    repeat (10) @(negedge clk);
    checks++;
    if (n !== 0 || lb !== 0) begin
      errors++;
      $display("FAIL tmo_reply: got n=%0d flags=%0d expected n=0 flags=0", n, lb);
    end
    checks++;
    if (enabled_out !== mask_m || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_regs: got %h busy=%b expected %h busy=0",
               enabled_out, busy, mask_m);
    end
    test_read_all("t5");
    test_write(1'b1, 64'($urandom()), TMO - 1, "t5_edge");
    test_read_all("t5_edge");
  endtask

  task automatic test_drop();
    logic [7:0] q[$];
    logic [63:0] v;
    int n, lb;
    logic [NC-1:0] a, b;
    logic [PW-1:0] c, d;
    q.push_back(COMM_READ_PIN_MAP);
    run_cmd(q, PB, -1, 1'b1, v, n, lb, a, b, c, d);
    checks++;
    if (n !== PB || v !== 64'(pin_m) || lb !== 0) begin
      errors++;
      $display("FAIL drop: got n=%0d %h lat=%0d expected n=%0d %h lat=0",
               n, v, lb, PB, 64'(pin_m));
    end
  endtask

  task automatic test_reset_mid();
    int t;
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = COMM_WRITE_PIN_MAP;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h11;
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h22;
    rst = 1'b1;
    #1;
    checks++;
    if (enabled_out !== MR || pin_map_out !== PR || busy !== 1'b0 ||
        bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_arg: got %h/%h busy=%b start=%b data=%h expected %h/%h 0/0/00",
               enabled_out, pin_map_out, busy, bus.tx_start, bus.tx_data, MR, PR);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    mask_m = MR;
    pin_m = PR;
    test_read_all("t6");
    test_write(1'b1, 64'h0f0f, -1, "t6w");
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = COMM_READ_PIN_MAP;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    t = 0;
    while (bus.tx_start !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (t >= 50 || bus.tx_start !== 1'b0 || busy !== 1'b0 || enabled_out !== MR) begin
      errors++;
      $display("FAIL rst_mid_tx: got wait=%0d start=%b busy=%b mask=%h expected <50 0/0 %h",
               t, bus.tx_start, busy, enabled_out, MR);
    end
    @(negedge clk);
    rst = 1'b0;
    mask_m = MR;
    repeat (20) @(negedge clk);
    test_read_all("t6b");
  endtask

  task automatic test_protocol();
    checks++;
    if (tx_viol !== 0) begin
      errors++;
      $display("FAIL tx_protocol: got %0d violations expected 0", tx_viol);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    mask_m = MR;
    pin_m = PR;
    test_reset();
    test_read();
    test_write_mask();
    test_write_pin();
    test_random_writes();
    test_nak();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
